input_debouncer: RTL and testbench

//   Conditions a raw asynchronous input (push-button, switch) into a clean,

---
 rtl/input_debouncer_pkg.sv | 11 +
 rtl/input_debouncer_sync_2ff.sv | 24 ++
 rtl/input_debouncer.sv | 104 ++++++++++
 tb/tb_input_debouncer.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared state encoding for the input debouncer FSM.
package input_debouncer_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        WAIT_LOW    = 2'b11
    } state_e;

endpackage

// File: rtl/input_debouncer_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reusable for other CDC paths.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous input into a registered level plus one-cycle rise/fall pulses.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int                   CNT_WIDTH = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 s;
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 level_q, level_d;
    logic                 rise_q, rise_d;
    logic                 fall_q, fall_d;

    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (raw_in),
        .q       (s)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // cnt counts consecutive samples at the new value; the first one is taken on entry to WAIT.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LOW: begin
                if (s) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase
    end

    // Only a WAIT->opposite-STABLE commit moves the level; glitch rejections fall back silently.
    always_comb begin
        rise_d  = (state_q == WAIT_HIGH) && (state_d == STABLE_HIGH);
        fall_d  = (state_q == WAIT_LOW)  && (state_d == STABLE_LOW);
        level_d = level_q;
        if (rise_d) level_d = 1'b1;
        if (fall_d) level_d = 1'b0;
    end

    assign level_out  = level_q;
    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with DEBOUNCE_CYCLES=4: expected pulses are queued at drive time.
module tb_input_debouncer;

    localparam int DC = 4;

    typedef struct {
        int   edge_n;
        logic rise;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic raw_in = 1'b0;
    logic level_out, rise_pulse, fall_pulse;

    exp_t exp_q[$];
    logic exp_level = 1'b0;
    int   cyc = 0;
    int   n_assert = 0;
    int   n_fail = 0;

    input_debouncer #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .raw_in     (raw_in),
        .level_out  (level_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    // One clock edge, then compare every output against the scoreboard.
    task automatic cycle();
        exp_t e;
        logic er, ef;
        @(posedge clk);
        #1;
        cyc++;
        er = 1'b0;
        ef = 1'b0;
        if (exp_q.size() > 0 && exp_q[0].edge_n == cyc) begin
            e         = exp_q.pop_front();
            er        = e.rise;
            ef        = !e.rise;
            exp_level = e.rise;
        end
        check("rise_pulse", rise_pulse, er);
        check("fall_pulse", fall_pulse, ef);
        check("level_out", level_out, exp_level);
        check("pulse_exclusive", rise_pulse & fall_pulse, 1'b0);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Settled change before edge cyc+1 commits at edge (cyc+1)+1+DC.
    task automatic drive_settle(input logic v);
        exp_t e;
        raw_in   = v;
        e.edge_n = cyc + 2 + DC;
        e.rise   = v;
        exp_q.push_back(e);
    endtask

    initial begin
        // 1: reset with raw_in toggling
        #2 reset_n = 1'b0;
        #1;
        check("reset_level", level_out, 1'b0);
        check("reset_rise", rise_pulse, 1'b0);
        check("reset_fall", fall_pulse, 1'b0);
        for (int i = 0; i < 5; i++) begin
            raw_in = ~raw_in;
            cycle();
        end
        raw_in  = 1'b0;
        reset_n = 1'b1;
        cycles(3);

        // 2: clean rise
        drive_settle(1'b1);
        cycles(9);

        // clean fall to return low
        drive_settle(1'b0);
        cycles(9);

        // 3: 3-cycle glitch rejected, then a held high accepted
        raw_in = 1'b1;
        cycles(3);
        raw_in = 1'b0;
        cycles(8);
        drive_settle(1'b1);
        cycles(9);

        // 4: clean fall from STABLE_HIGH
        drive_settle(1'b0);
        cycles(9);

        // 5: bounce for 20 cycles, then settle high
        for (int i = 0; i < 20; i++) begin
            raw_in = (i % 2 == 0);
            cycle();
        end
        drive_settle(1'b1);
        cycles(9);

        drive_settle(1'b0);
        cycles(9);

        // 6: async reset mid-WAIT_HIGH (cnt=2), asserted off-edge
        raw_in = 1'b1;
        cycles(4);
        #2 reset_n = 1'b0;
        #1;
        check("midwait_level", level_out, 1'b0);
        check("midwait_rise", rise_pulse, 1'b0);
        check("midwait_fall", fall_pulse, 1'b0);
        cycles(3);
        reset_n = 1'b1;
        begin
            exp_t e;
            e.edge_n = cyc + DC + 2;
            e.rise   = 1'b1;
            exp_q.push_back(e);
        end
        cycles(10);

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_drain: observed=%0d pending expected=0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
